// File: rtl/reg_file_ctx.sv
// Dual-bank register file with single-port style write/move access and a
// sequential bulk engine (clear / save-to-shadow / restore-from-shadow).
module reg_file_ctx #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [D-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         mov_en,
    input  logic [D-1:0] mov_src,
    input  logic [D-1:0] mov_dst,
    input  logic [D-1:0] rd_addr_a,
    input  logic [D-1:0] rd_addr_b,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_op,
    output logic [W-1:0] acc_out,
    output logic [W-1:0] rd_data_a,
    output logic [W-1:0] rd_data_b,
    output logic         cmd_ready,
    output logic         busy,
    output logic         done,
    output logic         dropped
);

    localparam int N = 2 ** D;

    localparam logic [1:0] OP_CLEAR   = 2'b00;
    localparam logic [1:0] OP_SAVE    = 2'b01;
    localparam logic [1:0] OP_RESTORE = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state, next_state;
    logic [1:0]   op_q;
    logic [D-1:0] idx;
    logic [W-1:0] primary [N];
    logic [W-1:0] shadow  [N];
    logic         accept;
    logic         last_idx;

    assign accept    = cmd_valid && (state == IDLE);
    assign last_idx  = (idx == {D{1'b1}});

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == DONE);
    assign done      = (state == DONE);

    assign acc_out   = primary[0];
    assign rd_data_a = primary[rd_addr_a];
    assign rd_data_b = primary[rd_addr_b];

    // Reserved op skips the walk entirely so the requester still sees a done pulse.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (cmd_op == OP_RSVD) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_idx) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_CLEAR;
            idx     <= '0;
            dropped <= 1'b0;
        end else begin
            state   <= next_state;
            dropped <= (state != IDLE) && (wr_en || mov_en);
            if (accept) begin
                op_q <= cmd_op;
                idx  <= '0;
            end else if ((state == RUN) && !last_idx) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Move wins over write when both are requested in the same IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                primary[i] <= '0;
            end
        end else if (state == IDLE) begin
            if (mov_en) begin
                primary[mov_dst] <= primary[mov_src];
            end else if (wr_en) begin
                primary[wr_addr] <= wr_data;
            end
        end else if (state == RUN) begin
            case (op_q)
                OP_CLEAR:   primary[idx] <= '0;
                OP_RESTORE: primary[idx] <= shadow[idx];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else if ((state == RUN) && (op_q == OP_SAVE)) begin
            shadow[idx] <= primary[idx];
        end
    end

endmodule

// File: tb/tb_reg_file_ctx.sv
// Scoreboard-driven bench for reg_file_ctx: a reference model of both banks
// supplies expected reads, pushed to a queue and popped as the DUT is sampled.
module tb_reg_file_ctx;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         mov_en;
    logic [D-1:0] mov_src;
    logic [D-1:0] mov_dst;
    logic [D-1:0] rd_addr_a;
    logic [D-1:0] rd_addr_b;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] acc_out;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
    logic         cmd_ready;
    logic         busy;
    logic         done;
    logic         dropped;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_prim [N];
    logic [W-1:0] m_shad [N];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] expv;

    reg_file_ctx #(.W(W), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mov_en    (mov_en),
        .mov_src   (mov_src),
        .mov_dst   (mov_dst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .acc_out   (acc_out),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prim[i] = '0;
            m_shad[i] = '0;
        end
    endtask

    task automatic model_op(input logic [1:0] op);
        for (int i = 0; i < N; i++) begin
            case (op)
                2'b00:   m_prim[i] = '0;
                2'b01:   m_shad[i] = m_prim[i];
                2'b10:   m_prim[i] = m_shad[i];
                default: ;
            endcase
        end
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) begin
            wr_en   = 1'b1;
            wr_addr = D'(i);
            wr_data = base + W'(i);
            step();
            m_prim[i] = base + W'(i);
        end
        wr_en = 1'b0;
    endtask

    // Issues one bulk op and counts busy cycles and done pulses until idle.
    task automatic run_op(input logic [1:0] op, output int busy_cyc, output int done_cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        step();
        cmd_valid = 1'b0;
        busy_cyc  = 0;
        done_cnt  = 0;
        while (busy && busy_cyc < 40) begin
            if (done) done_cnt++;
            busy_cyc++;
            step();
        end
        model_op(op);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (acc_out !== 8'h00)   begin bad++; $display("[TB] FAIL reset_acc got=%h want=00", acc_out); end
        total++; if (rd_data_a !== 8'h00) begin bad++; $display("[TB] FAIL reset_rda got=%h want=00", rd_data_a); end
        total++; if (rd_data_b !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdb got=%h want=00", rd_data_b); end
        total++; if (cmd_ready !== 1'b1)  begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", cmd_ready); end
        total++; if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0 || dropped !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses got=%b%b want=00", done, dropped); end
        step();
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_write();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        #1;
        total++; if (rd_data_a !== 8'h00) begin bad++; $display("[TB] FAIL write_pre_edge got=%h want=00", rd_data_a); end
        m_prim[3] = 8'hA5;
        exp_q.push_back(m_prim[3]);
        exp_q.push_back(m_prim[3]);
        step();
        wr_en = 1'b0;
        expv = exp_q.pop_front();
        total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL write_rda got=%h want=%h", rd_data_a, expv); end
        expv = exp_q.pop_front();
        total++; if (rd_data_b !== expv) begin bad++; $display("[TB] FAIL write_rdb got=%h want=%h", rd_data_b, expv); end
        total++; if (acc_out !== m_prim[0]) begin bad++; $display("[TB] FAIL write_acc got=%h want=%h", acc_out, m_prim[0]); end
    endtask

    task automatic test_move();
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h11; step(); m_prim[2] = 8'h11;
        wr_addr = 4'd5; wr_data = 8'h22; step(); m_prim[5] = 8'h22;
        mov_en = 1'b1; mov_src = 4'd2; mov_dst = 4'd5;
        wr_addr = 4'd5; wr_data = 8'hFF;
        m_prim[5] = m_prim[2];
        exp_q.push_back(m_prim[5]);
        step();
        mov_en = 1'b0; wr_en = 1'b0;
        rd_addr_a = 4'd5; rd_addr_b = 4'd2;
        #1;
        expv = exp_q.pop_front();
        total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL move_dst got=%h want=%h", rd_data_a, expv); end
        total++; if (rd_data_b !== 8'h11) begin bad++; $display("[TB] FAIL move_src got=%h want=11", rd_data_b); end
        total++; if (dropped !== 1'b0) begin bad++; $display("[TB] FAIL move_dropped got=%b want=0", dropped); end
    endtask

    task automatic test_bulk();
        int bc, dc;
        logic [1:0] ops [3];
        ops[0] = 2'b01; ops[1] = 2'b00; ops[2] = 2'b10;
        fill(8'h01);
        for (int k = 0; k < 3; k++) begin
            run_op(ops[k], bc, dc);
            total++; if (bc !== 17) begin bad++; $display("[TB] FAIL bulk_busy op=%0d got=%0d want=17", ops[k], bc); end
            total++; if (dc !== 1)  begin bad++; $display("[TB] FAIL bulk_done op=%0d got=%0d want=1", ops[k], dc); end
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL bulk_ready got=%b want=1", cmd_ready); end
        for (int i = 0; i < N; i++) exp_q.push_back(m_prim[i]);
        for (int i = 0; i < N; i++) begin
            rd_addr_a = D'(i);
            #1;
            expv = exp_q.pop_front();
            total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL bulk_reg%0d got=%h want=%h", i, rd_data_a, expv); end
        end
        total++; if (acc_out !== 8'h01) begin bad++; $display("[TB] FAIL bulk_acc got=%h want=01", acc_out); end
    endtask

    task automatic test_drop();
        int cyc, dc;
        cmd_valid = 1'b1; cmd_op = 2'b00;
        step();
        cmd_valid = 1'b0;
        step(); step();
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h55;
        cmd_valid = 1'b1; cmd_op = 2'b10;
        step();
        wr_en = 1'b0; cmd_valid = 1'b0;
        total++; if (dropped !== 1'b1) begin bad++; $display("[TB] FAIL drop_pulse got=%b want=1", dropped); end
        step();
        total++; if (dropped !== 1'b0) begin bad++; $display("[TB] FAIL drop_clear got=%b want=0", dropped); end
        cyc = 0; dc = 0;
        while (busy && cyc < 40) begin
            if (done) dc++;
            cyc++;
            step();
        end
        model_op(2'b00);
        total++; if (dc !== 1) begin bad++; $display("[TB] FAIL drop_done got=%0d want=1", dc); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_no_queue got=%b want=0", busy); end
        exp_q.push_back(m_prim[7]);
        rd_addr_a = 4'd7;
        #1;
        expv = exp_q.pop_front();
        total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL drop_r7 got=%h want=%h", rd_data_a, expv); end
    endtask

    task automatic test_reserved();
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h77; step(); wr_en = 1'b0; m_prim[1] = 8'h77;
        cmd_valid = 1'b1; cmd_op = 2'b11;
        step();
        cmd_valid = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL rsvd_done got=%b%b want=11", done, busy); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rsvd_ready1 got=%b want=0", cmd_ready); end
        step();
        total++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL rsvd_ready2 got=%b%b want=10", cmd_ready, done); end
        exp_q.push_back(m_prim[1]);
        rd_addr_a = 4'd1;
        #1;
        expv = exp_q.pop_front();
        total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL rsvd_r1 got=%h want=%h", rd_data_a, expv); end
        total++; if (acc_out !== m_prim[0]) begin bad++; $display("[TB] FAIL rsvd_acc got=%h want=%h", acc_out, m_prim[0]); end
    endtask

    task automatic test_reset_midrun();
        int bc, dc, seen;
        fill(8'h80);
        run_op(2'b01, bc, dc);
        run_op(2'b00, bc, dc);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        step();
        cmd_valid = 1'b0;
        repeat (7) step();
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrun_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL midrun_state got=%b%b%b want=100", cmd_ready, busy, done); end
        for (int i = 0; i < N; i++) exp_q.push_back(m_prim[i]);
        for (int i = 0; i < N; i++) begin
            rd_addr_a = D'(i);
            #1;
            expv = exp_q.pop_front();
            total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL midrun_reg%0d got=%h want=%h", i, rd_data_a, expv); end
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) seen++;
            step();
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL midrun_nodone got=%0d want=0", seen); end
        run_op(2'b10, bc, dc);
        exp_q.push_back(m_prim[5]);
        rd_addr_a = 4'd5;
        #1;
        expv = exp_q.pop_front();
        total++; if (rd_data_a !== expv) begin bad++; $display("[TB] FAIL midrun_shadow got=%h want=%h", rd_data_a, expv); end
    endtask

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mov_en = 1'b0; mov_src = '0; mov_dst = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        cmd_valid = 1'b0; cmd_op = 2'b00;
        test_reset();
        test_write();
        test_move();
        test_bulk();
        test_drop();
        test_reserved();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_ctx.md
REG_FILE_CTX -- requirements
Module: reg_file_ctx

Interface
REQ-001 SHALL have parameter W, default 8, register data width in bits.
REQ-002 SHALL have parameter D, default 4, address width; register count N = 2**D.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write wr_data into register wr_addr.
REQ-006 SHALL have port wr_addr  input  D  write target index.
REQ-007 SHALL have port wr_data  input  W  write data.
REQ-008 SHALL have port mov_en  input  1  copy register mov_src into register mov_dst.
REQ-009 SHALL have port mov_src  input  D  move source index.
REQ-010 SHALL have port mov_dst  input  D  move destination index.
REQ-011 SHALL have port rd_addr_a  input  D  read port A index.
REQ-012 SHALL have port rd_addr_b  input  D  read port B index.
REQ-013 SHALL have port cmd_valid  input  1  bulk command request.
REQ-014 SHALL have port cmd_op  input  2  bulk op: 00 clear, 01 save, 10 restore, 11 reserved.
REQ-015 SHALL have port acc_out  output  W  primary register 0 (accumulator).
REQ-016 SHALL have port rd_data_a  output  W  primary register rd_addr_a.
REQ-017 SHALL have port rd_data_b  output  W  primary register rd_addr_b.
REQ-018 SHALL have port cmd_ready  output  1  high in IDLE only.
REQ-019 SHALL have port busy  output  1  high in RUN or DONE.
REQ-020 SHALL have port done  output  1  one-cycle pulse at bulk-op completion.
REQ-021 SHALL have port dropped  output  1  registered one-cycle pulse: wr_en or mov_en ignored while busy.

Function
REQ-022 SHALL hold two banks of N x W registers: primary (readable) and shadow (not directly readable).
REQ-023 SHALL drive acc_out, rd_data_a, rd_data_b combinationally from primary bank; same-cycle writes visible only after the edge.
REQ-024 SHALL, in IDLE, perform mov_en at the edge: primary[mov_dst] <= primary[mov_src] (pre-edge value).
REQ-025 SHALL, in IDLE, perform wr_en when mov_en low: primary[wr_addr] <= wr_data.
REQ-026 SHALL, when mov_en and wr_en both high in IDLE, perform the move only; wr_en is discarded without dropped.
REQ-027 SHALL implement FSM states IDLE, RUN, DONE; IDLE -> RUN on cmd_valid & cmd_ready with cmd_op != 11, latching op, idx <= 0.
REQ-028 SHALL, on accepted cmd_op 11, go IDLE -> DONE directly with no register change.
REQ-029 SHALL process one index per RUN cycle: clear primary[idx] <= 0; save shadow[idx] <= primary[idx]; restore primary[idx] <= shadow[idx].
REQ-030 SHALL increment idx each RUN cycle; at idx == N-1 go RUN -> DONE; idx never wraps within an op.
REQ-031 SHALL go DONE -> IDLE unconditionally after one cycle with done = 1 in DONE.
REQ-032 SHALL perform a wr_en/mov_en present in the accepting IDLE cycle before the bulk op starts.
REQ-033 SHALL ignore wr_en and mov_en in RUN and DONE, and assert dropped the following cycle.
REQ-034 SHALL ignore cmd_valid when cmd_ready is low; no queueing.
REQ-035 SHALL take N+1 cycles from acceptance edge to DONE exit (cmd_ready high again at edge N+1).

Reset
REQ-036 SHALL, while rst_n low, force all primary and shadow registers to 0, state IDLE, idx 0, done 0, dropped 0.
REQ-037 SHALL abort any bulk op on reset mid-run; partially processed registers read 0 after reset.
REQ-038 SHALL, with rst_n low, read acc_out = rd_data_a = rd_data_b = 0, cmd_ready = 1, busy = 0.

Verification
REQ-039 Reset then wr_en addr 3 data 0xA5, rd_addr_a=3 -> rd_data_a 0x00 before edge, 0xA5 after; acc_out 0.
REQ-040 Primary r2=0x11, r5=0x22; mov_en src 2 dst 5 with wr_en addr 5 data 0xFF -> r5=0x11, dropped 0.
REQ-041 Fill r0..r15 = i+1; save; clear; restore -> each op busy 17 cycles, done single pulse; final r_i = i+1, acc_out 0x01.
REQ-042 During clear, wr_en addr 7 data 0x55 -> ignored, dropped pulse next cycle, r7 = 0 at done.
REQ-043 cmd_op 11 accepted -> done next cycle, cmd_ready high after 2 edges, registers unchanged.
REQ-044 rst_n low at 8th RUN cycle of restore -> all registers 0, IDLE immediately, done never pulses.
